// File: rtl/cgol_pkg.sv
// Shared types and constants for the Game of Life generation sequencer.
package cgol_pkg;

    localparam int unsigned ROWS  = 8;
    localparam int unsigned COLS  = 8;
    localparam int unsigned ROW_W = $clog2(ROWS);

    typedef logic [COLS-1:0]  row_t;
    typedef logic [ROW_W-1:0] ridx_t;
    typedef row_t [ROWS-1:0]  board_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SWEEP  = 2'd1,
        COMMIT = 2'd2
    } seq_state_t;

endpackage

// File: rtl/cgol_row_window.sv
// Selects the centre row and its vertical neighbours for the current sweep row.
// CGOL_TORUS_EN: when defined, rows wrap vertically (torus); otherwise the
// rows beyond the top and bottom edges read as dead.
module cgol_row_window
    import cgol_pkg::*;
(
    input  board_t           board,
    input  logic [ROW_W-1:0] ptr,
    input  logic             en,
    output logic [COLS-1:0]  row_in,
    output logic [COLS-1:0]  row_a,
    output logic [COLS-1:0]  row_b
);

    ridx_t up;
    ridx_t dn;

    // Neighbour indices, wrapped modulo ROWS.
    always_comb begin
        up = (ptr == '0) ? ridx_t'(ROWS - 1) : ptr - 1'b1;
        dn = (ptr == ridx_t'(ROWS - 1)) ? '0 : ptr + 1'b1;
    end

    // Row outputs are only driven during a sweep.
    always_comb begin
        row_in = '0;
        row_a  = '0;
        row_b  = '0;
        if (en) begin
            row_in = board[ptr];
            row_a  = board[up];
            row_b  = board[dn];
`ifndef CGOL_TORUS_EN
            if (ptr == '0) begin
                row_a = '0;
            end
            if (ptr == ridx_t'(ROWS - 1)) begin
                row_b = '0;
            end
`endif
        end
    end

endmodule

// File: rtl/cgol_generation_sequencer.sv
// Holds the 8x8 Life board, sweeps it row by row through decoder_top and
// commits the next generation in one cycle. Vertical wrap is selected by
// CGOL_TORUS_EN (see cgol_row_window).
module cgol_generation_sequencer
    import cgol_pkg::*;
#(
    parameter int unsigned GEN_W = 16
) (
    input  logic             ph1,
    input  logic             reset,
    input  logic             load_en,
    input  logic [ROW_W-1:0] load_addr,
    input  logic [COLS-1:0]  load_data,
    input  logic             step,
    output logic [COLS-1:0]  row_in,
    output logic [COLS-1:0]  row_a,
    output logic [COLS-1:0]  row_b,
    input  logic [COLS-1:0]  row_out,
    input  logic [ROW_W-1:0] disp_addr,
    output logic [COLS-1:0]  disp_row,
    output logic             busy,
    output logic             done,
    output logic             stable,
    output logic [GEN_W-1:0] gen_count
);

    seq_state_t       state_q, state_d;
    board_t           board_q;
    board_t           shadow_q;
    ridx_t            ptr_q;
    logic             done_q;
    logic             stable_q;
    logic [GEN_W-1:0] gen_q;
    logic             win_en;

    // State register.
    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: step only starts a sweep from IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (step) state_d = SWEEP;
            SWEEP:   if (ptr_q == ridx_t'(ROWS - 1)) state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM-decoded outputs.
    always_comb begin
        busy   = (state_q != IDLE);
        win_en = (state_q == SWEEP);
    end

    // Board, shadow buffer, row pointer and generation bookkeeping.
    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset) begin
            board_q  <= '0;
            shadow_q <= '0;
            ptr_q    <= '0;
            done_q   <= 1'b0;
            stable_q <= 1'b0;
            gen_q    <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (load_en) begin
                        board_q[load_addr] <= load_data;
                    end
                    ptr_q <= '0;
                end
                SWEEP: begin
                    // Board stays untouched so every row sees the old generation.
                    shadow_q[ptr_q] <= row_out;
                    ptr_q           <= (ptr_q == ridx_t'(ROWS - 1)) ? '0 : ptr_q + 1'b1;
                end
                COMMIT: begin
                    board_q  <= shadow_q;
                    stable_q <= (shadow_q == board_q);
                    gen_q    <= gen_q + 1'b1;
                    done_q   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    cgol_row_window u_window (
        .board  (board_q),
        .ptr    (ptr_q),
        .en     (win_en),
        .row_in (row_in),
        .row_a  (row_a),
        .row_b  (row_b)
    );

    // Display read port and registered status outputs.
    always_comb begin
        disp_row  = board_q[disp_addr];
        done      = done_q;
        stable    = stable_q;
        gen_count = gen_q;
    end

endmodule

// File: tb/tb_cgol_generation_sequencer.sv
// Self-checking bench for cgol_generation_sequencer with a behavioural
// decoder_top stand-in and a whole-board Life reference model.
module tb_cgol_generation_sequencer;

`ifdef CGOL_TORUS_EN
    localparam bit TORUS = 1'b1;
`else
    localparam bit TORUS = 1'b0;
`endif

    logic        ph1 = 1'b0;
    logic        reset = 1'b0;
    logic        load_en = 1'b0;
    logic [2:0]  load_addr = '0;
    logic [7:0]  load_data = '0;
    logic        step = 1'b0;
    logic [2:0]  disp_addr = '0;
    logic [7:0]  row_in, row_a, row_b, row_out, disp_row;
    logic        busy, done, stable;
    logic [15:0] gen_count;

    int          n_assert = 0;
    int          n_fail = 0;

    // Reference state: bit r*8+c is row r, column c.
    logic [63:0] mb = '0;
    int          mgen = 0;
    logic        mstable = 1'b0;

    always #5 ph1 = ~ph1;

    cgol_generation_sequencer #(.GEN_W(16)) dut (
        .ph1       (ph1),
        .reset     (reset),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .step      (step),
        .row_in    (row_in),
        .row_a     (row_a),
        .row_b     (row_b),
        .row_out   (row_out),
        .disp_addr (disp_addr),
        .disp_row  (disp_row),
        .busy      (busy),
        .done      (done),
        .stable    (stable),
        .gen_count (gen_count)
    );

    // decoder_top stand-in: one row of Life with column wrap.
    function automatic logic [7:0] life_row(input logic [7:0] a, input logic [7:0] c,
                                            input logic [7:0] b);
        logic [7:0] r;
        int n;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            n = int'(a[(i + 7) % 8]) + int'(a[i]) + int'(a[(i + 1) % 8])
              + int'(c[(i + 7) % 8]) + int'(c[(i + 1) % 8])
              + int'(b[(i + 7) % 8]) + int'(b[i]) + int'(b[(i + 1) % 8]);
            r[i] = (n == 3) || (c[i] && n == 2);
        end
        return r;
    endfunction

    always_comb row_out = life_row(row_a, row_in, row_b);

    // Whole-board next generation from cell neighbour counts.
    function automatic logic [63:0] model_next(input logic [63:0] b);
        logic [63:0] nx;
        int n, rr, cc;
        nx = '0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                n = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if (dr != 0 || dc != 0) begin
                            rr = r + dr;
                            cc = (c + dc + 8) % 8;
                            if (rr < 0 || rr > 7) begin
                                if (TORUS) rr = (rr + 8) % 8;
                                else rr = -1;
                            end
                            if (rr >= 0) n += int'(b[rr * 8 + cc]);
                        end
                    end
                end
                nx[r * 8 + c] = (n == 3) || (b[r * 8 + c] && n == 2);
            end
        end
        return nx;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_board(input string tag);
        for (int r = 0; r < 8; r++) begin
            disp_addr = 3'(r);
            #1;
            chk($sformatf("%s row%0d", tag, r), 64'(disp_row), 64'(mb[r * 8 +: 8]));
        end
    endtask

    task automatic check_disp(input string tag, input int r, input logic [7:0] exp);
        disp_addr = 3'(r);
        #1;
        chk(tag, 64'(disp_row), 64'(exp));
    endtask

    task automatic do_reset();
        @(negedge ph1);
        reset = 1'b0;
        @(negedge ph1);
        reset = 1'b1;
        mb = '0;
        mgen = 0;
        mstable = 1'b0;
    endtask

    task automatic load_row(input int r, input logic [7:0] d);
        @(negedge ph1);
        load_en = 1'b1;
        load_addr = 3'(r);
        load_data = d;
        @(posedge ph1);
        #1 load_en = 1'b0;
        mb[r * 8 +: 8] = d;
    endtask

    // One generation; optional step/load injections at edge Ek while busy,
    // and an optional load in the same cycle as the step.
    task automatic run_gen(input string tag, input int step_at, input int load_at,
                           input bit sim_load, input int sim_row, input logic [7:0] sim_data);
        int lat;
        int extra;
        logic [7:0] ea, eb;
        logic [63:0] nx;
        @(negedge ph1);
        step = 1'b1;
        if (sim_load) begin
            load_en = 1'b1;
            load_addr = 3'(sim_row);
            load_data = sim_data;
            mb[sim_row * 8 +: 8] = sim_data;
        end
        @(posedge ph1);
        #1;
        step = 1'b0;
        load_en = 1'b0;
        chk({tag, " busy E0"}, 64'(busy), 64'd1);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            if (k <= 8) begin
                ea = (k == 1) ? (TORUS ? mb[56 +: 8] : 8'h00) : mb[(k - 2) * 8 +: 8];
                eb = (k == 8) ? (TORUS ? mb[0 +: 8] : 8'h00) : mb[k * 8 +: 8];
                chk($sformatf("%s row_in p%0d", tag, k - 1), 64'(row_in),
                    64'(mb[(k - 1) * 8 +: 8]));
                chk($sformatf("%s row_a p%0d", tag, k - 1), 64'(row_a), 64'(ea));
                chk($sformatf("%s row_b p%0d", tag, k - 1), 64'(row_b), 64'(eb));
            end
            if (k == step_at) step = 1'b1;
            if (k == load_at) begin
                load_en = 1'b1;
                load_addr = 3'd5;
                load_data = 8'hFF;
            end
            @(posedge ph1);
            #1;
            step = 1'b0;
            load_en = 1'b0;
            if (done) begin
                lat = k;
                break;
            end
            chk($sformatf("%s busy E%0d", tag, k), 64'(busy), 64'd1);
        end
        chk({tag, " latency"}, 64'(lat), 64'd9);
        chk({tag, " busy at done"}, 64'(busy), 64'd0);
        nx = model_next(mb);
        mstable = (nx == mb);
        mb = nx;
        mgen++;
        chk({tag, " stable"}, 64'(stable), 64'(mstable));
        chk({tag, " gen_count"}, 64'(gen_count), 64'(16'(mgen)));
        chk({tag, " idle row_in"}, 64'({row_in, row_a, row_b}), 64'd0);
        check_board(tag);
        extra = 0;
        repeat (12) begin
            @(posedge ph1);
            #1;
            if (done) extra++;
        end
        chk({tag, " extra done"}, 64'(extra), 64'd0);
    endtask

    initial begin
        // Reset state.
        reset = 1'b0;
        repeat (3) @(posedge ph1);
        #1;
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst done", 64'(done), 64'd0);
        chk("rst stable", 64'(stable), 64'd0);
        chk("rst gen", 64'(gen_count), 64'd0);
        chk("rst rows", 64'({row_in, row_a, row_b}), 64'd0);
        check_board("rst");
        @(negedge ph1);
        reset = 1'b1;

        // Blinker, two phases.
        load_row(3, 8'b00011100);
        run_gen("blink1", 0, 0, 1'b0, 0, 8'h00);
        check_disp("blink1 r2", 2, 8'b00001000);
        check_disp("blink1 r3", 3, 8'b00001000);
        chk("blink1 gen", 64'(gen_count), 64'd1);
        run_gen("blink2", 0, 0, 1'b0, 0, 8'h00);
        check_disp("blink2 r3", 3, 8'b00011100);
        chk("blink2 gen", 64'(gen_count), 64'd2);

        // Still life block.
        do_reset();
        load_row(3, 8'b00011000);
        load_row(4, 8'b00011000);
        run_gen("block", 0, 0, 1'b0, 0, 8'h00);
        chk("block stable", 64'(stable), 64'd1);
        check_disp("block r4", 4, 8'b00011000);

        // Vertical wrap.
        do_reset();
        load_row(7, 8'b00000001);
        load_row(0, 8'b00000001);
        load_row(1, 8'b00000001);
        run_gen("wrap", 0, 0, 1'b0, 0, 8'h00);
        check_disp("wrap r0", 0, TORUS ? 8'b10000011 : 8'b00000000);

        // Step and load while busy are dropped.
        do_reset();
        load_row(3, 8'b00011100);
        run_gen("busyrule", 3, 5, 1'b0, 0, 8'h00);
        check_disp("busyrule r5", 5, 8'h00);
        chk("busyrule gen", 64'(gen_count), 64'd1);

        // Load and step in the same IDLE cycle.
        do_reset();
        run_gen("simul", 0, 0, 1'b1, 3, 8'b00011100);
        check_disp("simul r2", 2, 8'b00001000);
        check_disp("simul r4", 4, 8'b00001000);

        // Random boards, two generations each.
        for (int t = 0; t < 4; t++) begin
            do_reset();
            for (int r = 0; r < 8; r++) load_row(r, 8'($urandom));
            run_gen($sformatf("rand%0d a", t), 0, 0, 1'b0, 0, 8'h00);
            run_gen($sformatf("rand%0d b", t), 0, 0, 1'b0, 0, 8'h00);
        end

        // Reset mid-sweep at E4.
        load_row(2, 8'hA5);
        @(negedge ph1);
        step = 1'b1;
        @(posedge ph1);
        #1 step = 1'b0;
        repeat (4) @(posedge ph1);
        #1 reset = 1'b0;
        mb = '0;
        mgen = 0;
        #1;
        chk("midrst busy", 64'(busy), 64'd0);
        chk("midrst done", 64'(done), 64'd0);
        chk("midrst gen", 64'(gen_count), 64'd0);
        check_board("midrst");
        @(negedge ph1);
        reset = 1'b1;
        begin
            int dn;
            dn = 0;
            repeat (12) begin
                @(posedge ph1);
                #1;
                if (done) dn++;
            end
            chk("midrst no done", 64'(dn), 64'd0);
        end
        check_board("midrst after");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/cgol_generation_sequencer.md
Name: cgol_generation_sequencer

Overview:
- Holds the 8x8 Game of Life board and sweeps it row by row to compute the next generation.
- Each sweep cycle it drives one row plus its upper and lower neighbours into decoder_top, then captures row_out into a shadow buffer.
- After all 8 rows it commits the shadow buffer to the board in a single cycle.
- Also exposes the current board to the display path (dispcontrol) through a read port.

Parameters:
ROWS, 8, board height; pointer width is $clog2(ROWS)
COLS, 8, board width; must equal decoder_top row width
GEN_W, 16, width of the generation counter

Ports:
ph1  in  1  sole clock, rising-edge
reset  in  1  asynchronous, active-low reset
load_en  in  1  write seed row this cycle (honoured in IDLE only)
load_addr  in  3  seed row index
load_data  in  COLS  seed row contents
step  in  1  request one generation (honoured in IDLE only)
row_in  out  COLS  centre row to decoder_top
row_a  out  COLS  row above centre to decoder_top
row_b  out  COLS  row below centre to decoder_top
row_out  in  COLS  next-state row from decoder_top (combinational)
disp_addr  in  3  display read row index
disp_row  out  COLS  board[disp_addr], combinational read
busy  out  1  sweep/commit in progress
done  out  1  one-cycle pulse: new generation committed
stable  out  1  last commit produced no change
gen_count  out  GEN_W  generations committed since reset

Behaviour:
- Interface: one clock (ph1); reset is asynchronous and active-low.
- Reset (reset low, async):
  - board, shadow, ptr, gen_count cleared to 0.
  - state=IDLE.
  - busy=0, done=0, stable=0.
  - row_in/row_a/row_b=0.
- FSM states: IDLE, SWEEP, COMMIT.
- IDLE:
  - load_en writes board[load_addr]<=load_data at the edge.
  - step high at edge E0 -> state=SWEEP, ptr=0, busy=1 after E0.
  - load_en and step together: the load is applied at E0 and the sweep sees the loaded data.
- SWEEP:
  - Drives row_in=board[ptr], row_a=board[ptr-1], row_b=board[ptr+1]; indices are mod ROWS (see optional feature).
  - Each edge: shadow[ptr]<=row_out, ptr++.
  - At edge E8 (ptr==ROWS-1 captured) -> COMMIT.
  - Outside SWEEP, the three row outputs are 0.
- COMMIT (edge E9):
  - board<=shadow.
  - stable<=(shadow==board).
  - gen_count<=gen_count+1, wrapping at 2^GEN_W.
  - done<=1 for exactly one cycle; busy<=0; state=IDLE.
- Latency: done is visible 9 cycles after the step edge. busy is high for the cycles after E0 through E9 and never overlaps done.
- The board is never modified during SWEEP, so every row sees the old generation (no in-place corruption).
- Ignored while busy:
  - step while busy is dropped, not queued.
  - load_en while busy is dropped.
- disp_row always reflects the committed board and changes only at COMMIT or on an IDLE load.
- Reset mid-sweep aborts the sweep: the board is cleared and no done is issued.

Optional Feature:
- Macro: CGOL_TORUS_EN.
- Defined: vertical wrap. Row 0's upper neighbour is row ROWS-1, and row ROWS-1's lower neighbour is row 0. With decoder_top's column wrap this gives a full torus.
- Undefined: row_a=0 when ptr==0 and row_b=0 when ptr==ROWS-1 (dead boundary). Columns still wrap inside decoder_top.

Decomposition:
- Package cgol_pkg:
  - ROWS/COLS constants.
  - row_t (logic [COLS-1:0]).
  - row index type.
  - seq_state_t enum {IDLE, SWEEP, COMMIT}.
- One sub-module: cgol_row_window. Purely combinational; takes board and ptr, produces row_in/row_a/row_b; contains the CGOL_TORUS_EN boundary logic.
- FSM, shadow buffer and counters stay in the top.

Test Plan:
- Reset: hold reset low, toggle ph1 -> all outputs 0 and disp_row=0 for every disp_addr. Assert reset mid-sweep at E4 -> busy=0, no done pulse, board all zero.
- Blinker: load row3=8'b00011100, step -> done exactly 9 cycles after the step edge. Then rows 2,3,4 = 8'b00001000, all other rows 0, stable=0, gen_count=1. Second step -> row3=8'b00011100 again, gen_count=2.
- Still life: load rows 3,4 = 8'b00011000, step -> board unchanged, stable=1, gen_count=1.
- Vertical wrap: load rows 7,0,1 = 8'b00000001, step.
  - With CGOL_TORUS_EN: row0=8'b10000011, all other rows 0.
  - Without it: all rows 0.
- Busy rules: step again at E3 and load_en (row5=8'hFF) at E5 -> exactly one done pulse, gen_count+1 only, row5 unaffected by the load.
- Simultaneous load+step in IDLE: load row3=8'b00011100 with step in the same cycle -> committed result equals the blinker phase-2 pattern.
